// File: rtl/apb3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_pkg
//  Description : Shared state encoding and default widths for the fabric-side
//                APB3 command master.
//  Revision    : 1.0  initial release
// ============================================================================
package apb3_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Transfer phases of the APB3 initiator
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb3_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_wait_timer
//  Description : Counts ACCESS cycles with PREADY low. expired_o flags the
//                wait cycle that is the TIMEOUT_CYCLES-th one in a row, so the
//                master can abort on that same edge. TIMEOUT_CYCLES=0 removes
//                the counter and expired_o never asserts.
//  Revision    : 1.0  initial release
// ============================================================================
module apb3_wait_timer #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timer
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            // Clear has priority so a fresh transfer always starts from zero
            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (inc_i) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Wait-cycle counter register
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // The increment about to happen is the one that reaches the limit
            assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_timer
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/apb3_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : apb3_cmd_master
//  Description : Fabric-side APB3 initiator. Turns a valid/ready command into
//                one APB3 transfer and returns read data / error status on a
//                valid/ready response channel, with a bounded wait time.
//  Revision    : 1.0  initial release
// ============================================================================
module apb3_cmd_master
    import apb3_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic accept;
    logic wait_inc;
    logic wait_expired;

    assign accept   = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign wait_inc = (state_q == ACCESS) && !PREADY;

    apb3_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_ni    (PRESETN),
        .clr_i     (accept),
        .inc_i     (wait_inc),
        .expired_o (wait_expired)
    );

    // Next state, captured command/response fields and registered outputs
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A slave completion beats a timeout landing on the same cycle
                if (PREADY) begin
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (wait_expired) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake/strobe outputs are registered versions of the next state
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // FSM state register
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output and captured-data registers; reset drops any transfer in flight
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign PADDR       = paddr_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb3_cmd_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb3_cmd_master
//  Description : Self-checking bench for apb3_cmd_master. A transaction-level
//                model predicts each transfer's timeline and response from the
//                slave behaviour chosen for it; directed cases pin literals.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_apb3_cmd_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        PRESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    int n_chk  = 0;
    int n_fail = 0;

    // Slave behaviour chosen for the transfer being issued
    int          tx_W;
    bit          tx_serr;
    logic [31:0] tx_rdata;

    apb3_cmd_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK        (clk),
        .PRESETN     (PRESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Transaction-level model: each accepted command yields one SETUP
    // cycle, A access cycles (W+1 if the slave answers in time, else TO),
    // then a held response until rsp_ready.
    // ------------------------------------------------------------------
    bit          busy = 0;
    int          k;
    bit          m_wr, m_to, m_err;
    int          m_A;
    logic [31:0] m_addr, m_wd, m_rdata;
    bit          last_wr = 0;
    logic [31:0] last_addr = 0, last_wd = 0;

    always @(negedge clk) begin
        if (!PRESETN) begin
            busy      = 0;
            last_wr   = 0;
            last_addr = 0;
            last_wd   = 0;
        end else if (!busy) begin
            chk("idle_psel", PSEL, 0);
            chk("idle_penable", PENABLE, 0);
            chk("idle_rsp_valid", rsp_valid, 0);
            chk("idle_cmd_ready", cmd_ready, 1);
            chk("idle_paddr_hold", PADDR, last_addr);
            chk("idle_pwrite_hold", PWRITE, last_wr);
            chk("idle_pwdata_hold", PWDATA, last_wd);
            if (cmd_valid && cmd_ready) begin
                busy    = 1;
                k       = 0;
                m_wr    = cmd_write;
                m_addr  = cmd_addr;
                m_wd    = cmd_wdata;
                m_to    = (tx_W >= TO);
                m_A     = m_to ? TO : tx_W + 1;
                m_rdata = (m_to || m_wr) ? 32'h0 : tx_rdata;
                m_err   = m_to ? 1'b1 : tx_serr;
                last_wr = cmd_write;
                last_addr = cmd_addr;
                last_wd = cmd_wdata;
            end
        end else begin
            k++;
            chk("busy_cmd_ready", cmd_ready, 0);
            chk("paddr", PADDR, m_addr);
            chk("pwrite", PWRITE, m_wr);
            chk("pwdata", PWDATA, m_wd);
            if (k == 1) begin
                chk("setup_psel", PSEL, 1);
                chk("setup_penable", PENABLE, 0);
                chk("setup_rsp_valid", rsp_valid, 0);
            end else if (k <= 1 + m_A) begin
                chk("access_psel", PSEL, 1);
                chk("access_penable", PENABLE, 1);
                chk("access_rsp_valid", rsp_valid, 0);
            end else begin
                chk("resp_psel", PSEL, 0);
                chk("resp_penable", PENABLE, 0);
                chk("resp_valid", rsp_valid, 1);
                chk("resp_rdata", rsp_rdata, m_rdata);
                chk("resp_err", rsp_err, m_err);
                chk("resp_timeout", rsp_timeout, m_to);
                if (rsp_ready) busy = 0;
            end
        end
    end

    // Issue one command, play the slave, and consume the response
    task automatic run_tx(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int w, input bit serr, input logic [31:0] rdata,
                          input int rdelay, output int lat, output int pen,
                          output logic [31:0] r_rdata, output bit r_err, output bit r_to);
        bit ok, seen, done;
        int n, d;
        tx_W      = w;
        tx_serr   = serr;
        tx_rdata  = rdata;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("cmd_accept_bound", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        n = 0; d = 0; seen = 0; done = 0;
        lat = 0; pen = 0; r_rdata = 0; r_err = 0; r_to = 0;
        for (int it = 1; it <= 100 && !done; it++) begin
            if (it > 1) begin
                @(posedge clk);
                #1;
            end
            if (rsp_ready) begin
                rsp_ready = 1'b0;
                done = 1;
            end else begin
                if (PSEL && PENABLE) begin
                    n++;
                    pen++;
                    PREADY  = (n == w + 1);
                    PRDATA  = PREADY ? rdata : $urandom;
                    PSLVERR = PREADY ? serr : 1'($urandom);
                end else begin
                    PREADY  = 1'($urandom);
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom);
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen    = 1;
                        lat     = it;
                        r_rdata = rsp_rdata;
                        r_err   = rsp_err;
                        r_to    = rsp_timeout;
                    end
                    if (d == rdelay) rsp_ready = 1'b1;
                    else d++;
                end
            end
        end
        if (!done) chk("rsp_bound", 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, pen;
        logic [31:0] rd;
        bit er, to;
        bit ok;

        PRESETN = 1'b1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
        rsp_ready = 0; PRDATA = 0; PREADY = 0; PSLVERR = 0;
        tx_W = 0; tx_serr = 0; tx_rdata = 0;
        #2 PRESETN = 1'b0;
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_err", rsp_err, 0);
        repeat (3) @(negedge clk);
        #1 PRESETN = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Write, zero-wait
        run_tx(1, 32'h000000A0, 32'h00000003, 0, 0, 32'hDEADBEEF, 0, lat, pen, rd, er, to);
        chk("wr0_latency", lat, 3);
        chk("wr0_penable_cycles", pen, 1);
        chk("wr0_rdata", rd, 0);
        chk("wr0_err", er, 0);
        chk("wr0_paddr_held", PADDR, 32'h000000A0);
        chk("wr0_pwdata_held", PWDATA, 32'h00000003);

        // Read, two wait states
        run_tx(0, 32'h00000090, 32'h11111111, 2, 0, 32'h00000002, 0, lat, pen, rd, er, to);
        chk("rd2_penable_cycles", pen, 3);
        chk("rd2_latency", lat, 5);
        chk("rd2_rdata", rd, 32'h2);
        chk("rd2_err", er, 0);

        // Slave error
        run_tx(0, 32'h00000004, 32'h0, 0, 1, 32'h12345678, 0, lat, pen, rd, er, to);
        chk("slverr_err", er, 1);
        chk("slverr_timeout", to, 0);
        chk("slverr_rdata", rd, 32'h12345678);

        // Timeout: slave never ready
        run_tx(0, 32'h00000010, 32'h0, 10, 0, 32'hCAFEF00D, 0, lat, pen, rd, er, to);
        chk("to_penable_cycles", pen, 4);
        chk("to_latency", lat, 6);
        chk("to_err", er, 1);
        chk("to_timeout", to, 1);
        chk("to_rdata", rd, 0);

        // Response backpressure
        run_tx(0, 32'h00000020, 32'h0, 1, 0, 32'hA5A5A5A5, 5, lat, pen, rd, er, to);
        chk("bp_rdata", rd, 32'hA5A5A5A5);
        chk("bp_err", er, 0);

        // PREADY on the expiry cycle completes normally
        run_tx(1, 32'h00000030, 32'h77, 3, 0, 32'h99, 0, lat, pen, rd, er, to);
        chk("race_penable_cycles", pen, 4);
        chk("race_timeout", to, 0);
        chk("race_err", er, 0);
        chk("race_rdata", rd, 0);

        // Reset during a waited ACCESS phase
        tx_W = 50; tx_serr = 0; tx_rdata = 0;
        cmd_write = 0; cmd_addr = 32'h00000040; cmd_wdata = 0; cmd_valid = 1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("rst_test_accept_bound", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        PREADY = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_penable", PENABLE, 1);
        #2 PRESETN = 1'b0;
        #1;
        chk("async_rst_psel", PSEL, 0);
        chk("async_rst_penable", PENABLE, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        #1 PRESETN = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_cmd_ready", cmd_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_rsp", rsp_valid, 0);

        // Randomized transfers
        for (int t = 0; t < 60; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
                PREADY    = 1'($urandom);
                PRDATA    = $urandom;
                @(posedge clk);
                #1;
            end
            run_tx(1'($urandom), $urandom, $urandom, $urandom_range(0, 6), 1'($urandom),
                   $urandom, $urandom_range(0, 3), lat, pen, rd, er, to);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
